edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter_pkg.sv | 16 +
 rtl/edge_event_arbiter_edge_chan.sv | 35 +++
 rtl/edge_event_arbiter.sv | 100 ++++++++++
 tb/tb_edge_event_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared state encodings for the edge event arbiter: the per-channel edge
// detector and the present/acknowledge arbiter.
package edge_event_arbiter_pkg;

    typedef enum logic [1:0] {
        DET_ZERO = 2'b00,
        DET_EDGE = 2'b01,
        DET_ONE  = 2'b10
    } det_state_t;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/edge_event_arbiter_edge_chan.sv
// Per-channel Moore rising-edge detector: tick is high only in EDGE, so a
// level that rises and stays high yields exactly one tick.
module edge_chan
    import edge_event_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic tick
);

    det_state_t state, state_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= DET_ZERO;
        else       state <= state_next;
    end

    // NOTE: next-state is defaulted to the current state before the case, so
    // unlisted branches hold instead of inferring a latch.
    always_comb begin
        state_next = state;
        case (state)
            DET_ZERO: if (level)  state_next = DET_EDGE;
            DET_EDGE: state_next = level ? DET_ONE : DET_ZERO;
            DET_ONE:  if (!level) state_next = DET_ZERO;
            default:  state_next = DET_ZERO;
        endcase
    end

    assign tick = (state == DET_EDGE);

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges from NCH level channels into pending bits and presents
// them one at a time, round-robin from the channel after the last one retired.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] level,
    input  logic           ack,
    output logic           ticc_valid,
    output logic [IDW-1:0] ticc_id,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] overrun
);

    logic [NCH-1:0] tick;
    logic [NCH-1:0] retire_vec;
    logic [NCH-1:0] pending_next, overrun_next;
    logic [IDW-1:0] ptr, ptr_next, id_next, sel;
    logic           found, retire;
    arb_state_t     state, state_next;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        edge_chan u_chan (
            .clk   (clk),
            .reset (reset),
            .level (level[i]),
            .tick  (tick[i])
        );
    end

    // First pending channel at or above ptr, wrapping; idx stays below NCH.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        id_next    = ticc_id;
        ptr_next   = ptr;
        retire     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    id_next    = sel;
                    state_next = ARB_PRESENT;
                end
            end
            ARB_PRESENT: begin
                if (ack) begin
                    retire     = 1'b1;
                    ptr_next   = (ticc_id == IDW'(NCH - 1)) ? '0 : ticc_id + IDW'(1);
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        retire_vec = '0;
        if (retire) retire_vec[ticc_id] = 1'b1;
    end

    // A tick landing on the retiring edge is a fresh event, not an overrun.
    assign pending_next = tick | (pending & ~retire_vec);
    assign overrun_next = (overrun | (tick & pending)) & ~retire_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARB_IDLE;
            ticc_id <= '0;
            ptr     <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            state   <= state_next;
            ticc_id <= id_next;
            ptr     <= ptr_next;
            pending <= pending_next;
            overrun <= overrun_next;
        end
    end

    assign ticc_valid = (state == ARB_PRESENT);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NCH=4): latency, round-robin order,
// fairness, overrun, tick-on-ack and reset while presenting.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] level;
    logic       ack;
    logic       ticc_valid;
    logic [1:0] ticc_id;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter #(.NCH(4), .IDW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .level      (level),
        .ack        (ack),
        .ticc_valid (ticc_valid),
        .ticc_id    (ticc_id),
        .pending    (pending),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        level = 4'b0000;
        ack   = 1'b0;
        #1;
        check("rst_valid",   32'(ticc_valid), 32'd0);
        check("rst_id",      32'(ticc_id),    32'd0);
        check("rst_pending", 32'(pending),    32'h0);
        check("rst_overrun", 32'(overrun),    32'h0);
        step();
        reset = 1'b0;

        // Single pulse on ch2, ack tied high
        ack   = 1'b1;
        level = 4'b0100;
        step();
        check("sp_t0_valid",   32'(ticc_valid), 32'd0);
        check("sp_t0_pending", 32'(pending),    32'h0);
        step();
        check("sp_t1_valid",   32'(ticc_valid), 32'd0);
        check("sp_t1_pending", 32'(pending),    32'h4);
        step();
        check("sp_t2_valid",   32'(ticc_valid), 32'd1);
        check("sp_t2_id",      32'(ticc_id),    32'd2);
        level = 4'b0000;
        step();
        check("sp_t3_valid",   32'(ticc_valid), 32'd0);
        check("sp_t3_pending", 32'(pending),    32'h0);
        step();
        check("sp_t4_valid",   32'(ticc_valid), 32'd0);

        // Round-robin from ptr=0 with all channels rising together
        reset = 1'b1;
        #1;
        reset = 1'b0;
        level = 4'b1111;
        step();
        check("rr_t0_pending", 32'(pending), 32'h0);
        step();
        check("rr_t1_pending", 32'(pending), 32'hF);
        check("rr_t1_valid",   32'(ticc_valid), 32'd0);
        step();
        check("rr_t2_valid", 32'(ticc_valid), 32'd1);
        check("rr_t2_id",    32'(ticc_id),    32'd0);
        step();
        check("rr_t3_valid",   32'(ticc_valid), 32'd0);
        check("rr_t3_pending", 32'(pending),    32'hE);
        step();
        check("rr_t4_id",      32'(ticc_id),    32'd1);
        check("rr_t4_valid",   32'(ticc_valid), 32'd1);
        step();
        check("rr_t5_pending", 32'(pending),    32'hC);
        step();
        check("rr_t6_id",      32'(ticc_id),    32'd2);
        check("rr_t6_valid",   32'(ticc_valid), 32'd1);
        step();
        check("rr_t7_pending", 32'(pending),    32'h8);
        step();
        check("rr_t8_id",      32'(ticc_id),    32'd3);
        check("rr_t8_valid",   32'(ticc_valid), 32'd1);
        step();
        check("rr_t9_valid",   32'(ticc_valid), 32'd0);
        check("rr_t9_pending", 32'(pending),    32'h0);
        level = 4'b0000;
        ack   = 1'b0;
        step();

        // Fairness: ptr wrapped to 0 so ch1 wins over ch3, then ch3 over ch0
        level = 4'b1010;
        step();
        step();
        check("fa_t1_pending", 32'(pending), 32'hA);
        step();
        check("fa_t2_valid", 32'(ticc_valid), 32'd1);
        check("fa_t2_id",    32'(ticc_id),    32'd1);
        level = 4'b1011;
        step();
        check("fa_t3_valid",   32'(ticc_valid), 32'd1);
        check("fa_t3_id",      32'(ticc_id),    32'd1);
        check("fa_t3_pending", 32'(pending),    32'hA);
        ack = 1'b1;
        step();
        check("fa_t4_valid",   32'(ticc_valid), 32'd0);
        check("fa_t4_pending", 32'(pending),    32'h9);
        step();
        check("fa_t5_valid", 32'(ticc_valid), 32'd1);
        check("fa_t5_id",    32'(ticc_id),    32'd3);
        step();
        check("fa_t6_pending", 32'(pending), 32'h1);
        step();
        check("fa_t7_valid", 32'(ticc_valid), 32'd1);
        check("fa_t7_id",    32'(ticc_id),    32'd0);
        step();
        check("fa_t8_valid",   32'(ticc_valid), 32'd0);
        check("fa_t8_pending", 32'(pending),    32'h0);
        level = 4'b0000;
        ack   = 1'b0;
        step();

        // Overrun: ch0 rises twice before the first event is acknowledged
        level = 4'b0001;
        step();
        level = 4'b0000;
        step();
        check("ov_t1_pending", 32'(pending), 32'h1);
        check("ov_t1_overrun", 32'(overrun), 32'h0);
        level = 4'b0001;
        step();
        check("ov_t2_valid", 32'(ticc_valid), 32'd1);
        check("ov_t2_id",    32'(ticc_id),    32'd0);
        level = 4'b0000;
        step();
        check("ov_t3_overrun", 32'(overrun), 32'h1);
        check("ov_t3_pending", 32'(pending), 32'h1);
        step();
        check("ov_t4_valid",   32'(ticc_valid), 32'd1);
        check("ov_t4_overrun", 32'(overrun),    32'h1);
        ack = 1'b1;
        step();
        check("ov_t5_valid",   32'(ticc_valid), 32'd0);
        check("ov_t5_pending", 32'(pending),    32'h0);
        check("ov_t5_overrun", 32'(overrun),    32'h0);
        ack = 1'b0;
        step();
        check("ov_t6_valid", 32'(ticc_valid), 32'd0);

        // New ch1 tick on the same edge that acknowledges ch1
        level = 4'b0010;
        step();
        step();
        check("si_t1_pending", 32'(pending), 32'h2);
        step();
        check("si_t2_valid", 32'(ticc_valid), 32'd1);
        check("si_t2_id",    32'(ticc_id),    32'd1);
        level = 4'b0000;
        step();
        check("si_t3_valid", 32'(ticc_valid), 32'd1);
        level = 4'b0010;
        step();
        check("si_t4_overrun", 32'(overrun), 32'h0);
        ack = 1'b1;
        step();
        check("si_t5_valid",   32'(ticc_valid), 32'd0);
        check("si_t5_pending", 32'(pending),    32'h2);
        check("si_t5_overrun", 32'(overrun),    32'h0);
        ack = 1'b0;
        step();
        check("si_t6_valid", 32'(ticc_valid), 32'd1);
        check("si_t6_id",    32'(ticc_id),    32'd1);
        ack = 1'b1;
        step();
        check("si_t7_pending", 32'(pending), 32'h0);
        ack   = 1'b0;
        level = 4'b0000;
        step();

        // Reset pulse while presenting, level held high across it
        level = 4'b0100;
        step();
        step();
        step();
        check("mr_t2_valid", 32'(ticc_valid), 32'd1);
        check("mr_t2_id",    32'(ticc_id),    32'd2);
        reset = 1'b1;
        #1;
        check("mr_rst_valid",   32'(ticc_valid), 32'd0);
        check("mr_rst_id",      32'(ticc_id),    32'd0);
        check("mr_rst_pending", 32'(pending),    32'h0);
        check("mr_rst_overrun", 32'(overrun),    32'h0);
        reset = 1'b0;
        step();
        check("mr_t0_valid",   32'(ticc_valid), 32'd0);
        check("mr_t0_pending", 32'(pending),    32'h0);
        step();
        check("mr_t1_pending", 32'(pending),    32'h4);
        check("mr_t1_valid",   32'(ticc_valid), 32'd0);
        step();
        check("mr_t2b_valid", 32'(ticc_valid), 32'd1);
        check("mr_t2b_id",    32'(ticc_id),    32'd2);
        ack = 1'b1;
        step();
        check("mr_t3_valid",   32'(ticc_valid), 32'd0);
        check("mr_t3_pending", 32'(pending),    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
